multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/cpu_ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, FSM state
// encodings, datapath select codes and the internal control-word bundle.
package cpu_ctrl_pkg;

    // Opcodes from the instruction register
    localparam logic [3:0] OpRtype = 4'h0;
    localparam logic [3:0] OpAddi  = 4'h1;
    localparam logic [3:0] OpLw    = 4'h2;
    localparam logic [3:0] OpSw    = 4'h3;
    localparam logic [3:0] OpBeq   = 4'h4;
    localparam logic [3:0] OpBne   = 4'h5;
    localparam logic [3:0] OpJ     = 4'h6;
    localparam logic [3:0] OpJal   = 4'h7;
    localparam logic [3:0] OpHalt  = 4'hF;

    // ALUOp codes
    localparam logic [1:0] AluOpAdd  = 2'd0;
    localparam logic [1:0] AluOpSub  = 2'd1;
    localparam logic [1:0] AluOpFunk = 2'd2;

    // ALUSrcB codes
    localparam logic [1:0] AluSrcBRt    = 2'd0;
    localparam logic [1:0] AluSrcBOne   = 2'd1;
    localparam logic [1:0] AluSrcBImm   = 2'd2;
    localparam logic [1:0] AluSrcBImmSh = 2'd3;

    // PCSource codes
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    // FSM state encodings, exported on state_out for debug
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StJal     = 4'd11,
        StHalt    = 4'd12
    } state_e;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_not;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic       link_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ, OpJal, OpHalt};
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle CPU. Outputs decode from the
// registered state; the only combinational input paths are the memory-stall
// gating on mem_ready, the illegal-opcode pulse in DECODE and reset gating.
module multicycle_control
    import cpu_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] op,
    input  logic [2:0] funk,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteNot,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic       LinkReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] state_out,
    output logic       halted,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    // Opcode captured in DECODE so later states ignore changes on op
    logic [3:0] op_q, op_d;
    ctrl_t      ctrl;
    logic       mem_wait;

    // funk is decoded by alu_control, not here
    logic unused_funk;
    assign unused_funk = ^funk;

    // State and latched-opcode registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            op_q    <= OpRtype;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        op_d    = (state_q == StDecode) ? op : op_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (op)
                    OpRtype:      state_d = StExecR;
                    OpAddi:       state_d = StExecI;
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    OpJal:        state_d = StJal;
                    OpHalt:       state_d = StHalt;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAddr: begin
                state_d = (op_q == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWr: begin
                if (mem_ready) state_d = StFetch;
            end
            StExecR, StExecI: begin
                state_d = StAluWb;
            end
            StMemWb, StAluWb, StBranch, StJump, StJal: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign mem_wait = ~mem_ready &
                      ((state_q == StFetch) | (state_q == StMemRd) | (state_q == StMemWr));

    // Output decode from registered state, then stall and reset gating
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = AluSrcBOne;
                ctrl.alu_op    = AluOpAdd;
                ctrl.pc_source = PcSrcAlu;
            end
            StDecode: begin
                ctrl.alu_src_b = AluSrcBImmSh;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = AluSrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StExecR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = AluSrcBRt;
                ctrl.alu_op    = AluOpFunk;
            end
            StExecI: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = AluSrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StAluWb: begin
                ctrl.reg_write = 1'b1;
                // R-type writes rd, addi writes rt
                ctrl.reg_dst   = (op_q == OpRtype);
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = AluSrcBRt;
                ctrl.alu_op        = AluOpSub;
                ctrl.pc_source     = PcSrcAluOut;
                ctrl.pc_write_cond = (op_q == OpBeq);
                ctrl.pc_write_not  = (op_q == OpBne);
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcSrcJump;
            end
            StJal: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcSrcJump;
                ctrl.reg_write = 1'b1;
                ctrl.link_reg  = 1'b1;
            end
            default: ;
        endcase

        // A stalled access keeps its address/strobe but commits nothing
        if (mem_wait) begin
            ctrl.ir_write   = 1'b0;
            ctrl.pc_write   = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.reg_write  = 1'b0;
        end

        // Reset is asynchronous, so enables must drop without waiting for a clock
        if (!reset_n) begin
            ctrl.ir_write      = 1'b0;
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.pc_write_not  = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.reg_write     = 1'b0;
        end
    end

    assign IRWrite     = ctrl.ir_write;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCWriteNot  = ctrl.pc_write_not;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign LinkReg     = ctrl.link_reg;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;

    assign state_out  = state_q;
    assign halted     = reset_n & (state_q == StHalt);
    assign illegal_op = reset_n & (state_q == StDecode) & ~is_legal_op(op);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. Each instruction is
// expanded into an expected per-cycle trace from the instruction-level rules;
// a monitor pops and compares one trace entry per cycle.
module tb_multicycle_control;
    import cpu_ctrl_pkg::*;

    // Enable-vector bit positions, order matches the monitor's packing
    localparam logic [11:0] E_IRW  = 12'h800;
    localparam logic [11:0] E_PCW  = 12'h400;
    localparam logic [11:0] E_PCC  = 12'h200;
    localparam logic [11:0] E_PCN  = 12'h100;
    localparam logic [11:0] E_IORD = 12'h080;
    localparam logic [11:0] E_MRD  = 12'h040;
    localparam logic [11:0] E_MWR  = 12'h020;
    localparam logic [11:0] E_M2R  = 12'h010;
    localparam logic [11:0] E_RW   = 12'h008;
    localparam logic [11:0] E_RDST = 12'h004;
    localparam logic [11:0] E_SRCA = 12'h002;
    localparam logic [11:0] E_LINK = 12'h001;

    typedef struct {
        logic [3:0]  st;
        logic        mr;
        logic [3:0]  op;
        logic [11:0] en;
        logic [1:0]  srcb;
        logic [1:0]  pcs;
        logic [1:0]  aop;
        logic        h;
        logic        il;
    } cyc_t;

    logic       clock;
    logic       reset_n;
    logic [3:0] op;
    logic [2:0] funk;
    logic       mem_ready;
    logic       IRWrite, PCWrite, PCWriteCond, PCWriteNot, IorD, MemRead, MemWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA, LinkReg;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] state_out;
    logic       halted, illegal_op;

    int   checks;
    int   errors;
    int   cyc_no;
    cyc_t exp_q[$];

    multicycle_control dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op          (op),
        .funk        (funk),
        .mem_ready   (mem_ready),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCWriteNot  (PCWriteNot),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .LinkReg     (LinkReg),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .state_out   (state_out),
        .halted      (halted),
        .illegal_op  (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic cyc_t mk(input logic [3:0] st, input logic mr, input logic [3:0] o,
                                input logic [11:0] en, input logic [1:0] srcb,
                                input logic [1:0] pcs, input logic [1:0] aop,
                                input logic h, input logic il);
        cyc_t c;
        c.st = st; c.mr = mr; c.op = o; c.en = en; c.srcb = srcb;
        c.pcs = pcs; c.aop = aop; c.h = h; c.il = il;
        return c;
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal(input logic [3:0] o);
        return (o <= 4'h7) || (o == 4'hF);
    endfunction

    // Expand one instruction into its expected cycle trace, then drive it.
    // wf/wm: wait cycles in fetch / data access. open_end leaves the data
    // access stalled (no completing cycle).
    task automatic run_instr(input logic [3:0] o, input int wf, input int wm, input bit open_end);
        cyc_t plan[$];
        for (int i = 0; i < wf; i++)
            plan.push_back(mk(StFetch, 1'b0, rop(), E_MRD, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0));
        plan.push_back(mk(StFetch, 1'b1, rop(), E_MRD | E_IRW | E_PCW, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0));
        plan.push_back(mk(StDecode, rbit(), o, 12'h0, 2'd3, 2'd0, 2'd0, 1'b0, !legal(o)));
        case (o)
            4'h0: begin
                plan.push_back(mk(StExecR, rbit(), rop(), E_SRCA, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0));
                plan.push_back(mk(StAluWb, rbit(), rop(), E_RW | E_RDST, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
            end
            4'h1: begin
                plan.push_back(mk(StExecI, rbit(), rop(), E_SRCA, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0));
                plan.push_back(mk(StAluWb, rbit(), rop(), E_RW, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
            end
            4'h2, 4'h3: begin
                logic [3:0]  acc_st;
                logic [11:0] acc_en;
                acc_st = (o == 4'h2) ? 4'(StMemRd) : 4'(StMemWr);
                acc_en = (o == 4'h2) ? (E_MRD | E_IORD) : (E_MWR | E_IORD);
                plan.push_back(mk(StMemAddr, rbit(), rop(), E_SRCA, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0));
                for (int i = 0; i < wm; i++)
                    plan.push_back(mk(acc_st, 1'b0, rop(), acc_en, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
                if (!open_end) begin
                    plan.push_back(mk(acc_st, 1'b1, rop(), acc_en, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
                    if (o == 4'h2)
                        plan.push_back(mk(StMemWb, rbit(), rop(), E_RW | E_M2R,
                                          2'd0, 2'd0, 2'd0, 1'b0, 1'b0));
                end
            end
            4'h4: plan.push_back(mk(StBranch, rbit(), rop(), E_SRCA | E_PCC, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0));
            4'h5: plan.push_back(mk(StBranch, rbit(), rop(), E_SRCA | E_PCN, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0));
            4'h6: plan.push_back(mk(StJump, rbit(), rop(), E_PCW, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0));
            4'h7: plan.push_back(mk(StJal, rbit(), rop(), E_PCW | E_RW | E_LINK,
                                    2'd0, 2'd2, 2'd0, 1'b0, 1'b0));
            4'hF: begin
                for (int i = 0; i < 20; i++)
                    plan.push_back(mk(StHalt, rbit(), rop(), 12'h0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0));
            end
            default: ;
        endcase
        foreach (plan[i]) begin
            @(posedge clock);
            #1;
            mem_ready = plan[i].mr;
            op        = plan[i].op;
            funk      = 3'($urandom_range(0, 7));
            exp_q.push_back(plan[i]);
        end
    endtask

    // Monitor: one trace entry per cycle, sampled mid-cycle
    task automatic monitor();
        cyc_t        e;
        logic [31:0] got, want;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                got  = {6'd0, state_out, IRWrite, PCWrite, PCWriteCond, PCWriteNot, IorD, MemRead,
                        MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, LinkReg,
                        ALUSrcB, PCSource, ALUOp, halted, illegal_op};
                want = {6'd0, e.st, e.en, e.srcb, e.pcs, e.aop, e.h, e.il};
                chk($sformatf("cycle_%0d", cyc_no), got, want);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc_no    = 0;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        op        = 4'h9;
        funk      = 3'd0;
        fork
            monitor();
        join_none

        // Reset: state FETCH but all enables and memory strobes held low
        #3;
        chk("reset_state", 32'(state_out), 32'(StFetch));
        chk("reset_enables", {20'd0, IRWrite, PCWrite, PCWriteCond, PCWriteNot, MemRead, MemWrite,
                              RegWrite, MemtoReg, halted, illegal_op, IorD, LinkReg}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_hold_state", 32'(state_out), 32'(StFetch));
        chk("reset_hold_memread", 32'(MemRead), 32'd0);
        mem_ready = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b1;

        // Directed instructions
        run_instr(4'h0, 0, 0, 1'b0);   // R-type
        run_instr(4'h2, 0, 2, 1'b0);   // lw, 2 stalls in MEM_RD
        run_instr(4'h4, 0, 0, 1'b0);   // beq
        run_instr(4'h5, 0, 0, 1'b0);   // bne
        run_instr(4'h9, 0, 0, 1'b0);   // illegal
        run_instr(4'h1, 2, 0, 1'b0);   // addi with fetch stalls
        run_instr(4'h3, 1, 1, 1'b0);   // sw with stalls

        // Randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            int         r;
            logic [3:0] o;
            r = $urandom_range(0, 9);
            o = (r < 8) ? 4'(r) : 4'(8 + $urandom_range(0, 6));
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end

        // Reset during a stalled store: MemWrite must drop before any edge
        run_instr(4'h3, 0, 2, 1'b1);
        @(negedge clock);
        #1 reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("memwr_reset_memwrite", 32'(MemWrite), 32'd0);
        chk("memwr_reset_state", 32'(state_out), 32'(StFetch));
        chk("memwr_reset_memread", 32'(MemRead), 32'd0);
        #1 reset_n = 1'b1;
        run_instr(4'h0, 1, 0, 1'b0);

        // Halt held 20 cycles, then asynchronous exit via reset
        run_instr(4'hF, 0, 0, 1'b0);
        @(negedge clock);
        #1 reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("halt_reset_state", 32'(state_out), 32'(StFetch));
        #1 reset_n = 1'b1;
        run_instr(4'h7, 0, 0, 1'b0);
        run_instr(4'h6, 0, 0, 1'b0);

        repeat (3) @(negedge clock);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
